imem_bank: RTL and testbench
============================

IMEM_BANK -- requirements
Module: imem_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64: number of words; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-004 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port fetch_req  in  1: fetch request, sampled each cycle.
REQ-007 SHALL have port fetch_addr  in  ADDR_W: fetch byte address.
REQ-008 SHALL have port fetch_valid  out  1: fetch response strobe.
REQ-009 SHALL have port fetch_instr  out  DATA_W: fetched word.
REQ-010 SHALL have port fetch_fault  out  1: fetch address misaligned or out of range.
REQ-011 SHALL have port load_valid  in  1: loader write request.
REQ-012 SHALL have port load_ready  out  1: loader may write this cycle.
REQ-013 SHALL have port load_addr  in  ADDR_W: loader byte address.
REQ-014 SHALL have port load_data  in  DATA_W: loader write data.
REQ-015 SHALL have port load_err  out  1: one-cycle pulse when a write is dropped.
REQ-016 SHALL have port busy  out  1: clear sequence in progress.

Function
REQ-017 SHALL implement an FSM with states CLEAR and IDLE; CLEAR writes zero to index 0..DEPTH-1, one index per cycle, then goes to IDLE.
REQ-018 SHALL hold busy=1 and load_ready=0 in CLEAR; load_ready=1 and busy=0 in IDLE.
REQ-019 SHALL form word index as addr[$clog2(DEPTH)+1:2]; an address is valid when addr[1:0]==0 and addr < 4*DEPTH.
REQ-020 SHALL accept a fetch when fetch_req=1 in IDLE, and respond the next cycle with fetch_valid=1 for exactly one cycle: latency 1, back-to-back fetches allowed every cycle.
REQ-021 SHALL, on an invalid fetch address, return fetch_fault=1 and fetch_instr=0, with no effect on array contents.
REQ-022 SHALL drop fetch_req while busy, with no response.
REQ-023 SHALL write load_data when load_valid && load_ready and load_addr is valid; on an invalid address, drop the write and pulse load_err the next cycle.
REQ-024 SHALL, on a same-cycle fetch and load to the same index, return the old data (read-before-write); the new data is visible from the next fetch.
REQ-025 SHALL hold fetch_instr and fetch_fault at their last values when fetch_valid=0.

Reset
REQ-026 SHALL, on rst_n low, immediately enter CLEAR with clear index 0, fetch_valid=0, fetch_instr=0, fetch_fault=0 and load_err=0, including when reset asserts mid-clear or mid-fetch.
REQ-027 SHALL start clearing on the first clk edge after rst_n rises; busy falls exactly DEPTH cycles later.

Configuration
REQ-028 SHALL, with IMEM_PARITY_EN defined, store one even-parity bit per word, add output parity_err (1 bit, valid with fetch_valid), and check it on every valid fetch; CLEAR writes parity 0.
REQ-029 SHALL, without IMEM_PARITY_EN, have no parity storage and no parity_err port.

Structure
REQ-030 SHALL place the FSM state enum (CLEAR, IDLE) and the default DATA_W/DEPTH constants in shared package imem_pkg.
REQ-031 SHALL isolate the storage array, one synchronous write port and one registered read port, in sub-module imem_array; the FSM, address decode and faults live in imem_bank.

Verification
REQ-032 SHALL cover: release reset -> busy=1 for exactly 64 cycles, then load_ready=1; a fetch of any address returns 0x00000000.
REQ-033 SHALL cover: load 0x00000013 at address 0x10, then fetch 0x10 -> next cycle fetch_valid=1, fetch_instr=0x00000013, fetch_fault=0.
REQ-034 SHALL cover: fetch 0x102 (misaligned) and fetch 0x100 (out of range) -> fetch_fault=1, fetch_instr=0; a load to 0x100 -> load_err pulse, contents unchanged.
REQ-035 SHALL cover: same cycle, load 0xDEADBEEF at 0x8 and fetch 0x8 (old value 0x0) -> returns 0x0; the next fetch of 0x8 returns 0xDEADBEEF.
REQ-036 SHALL cover: assert rst_n low mid-clear at cycle 20 -> outputs reset immediately; after release the clear restarts and takes 64 cycles.
REQ-037 SHALL cover, with IMEM_PARITY_EN: force a flipped bit in a stored word -> parity_err=1 on the fetch of that word.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory bank: controller states and default geometry.
package imem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 64;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/imem_array.sv
// Word storage for imem_bank: one synchronous write port and one registered read port.
// A same-cycle read and write to one index returns the old word.
module imem_array #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_bank.sv
// Instruction memory bank: clear-on-reset FSM, fetch port with latency 1, loader write port.
// Define IMEM_PARITY_EN to store an even-parity bit per word and add the parity_err output.
module imem_bank
  import imem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  output logic              busy
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(4 * DEPTH);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && ({1'b0, a} < ADDR_LIM);
  endfunction

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_clr_idx, w_clr_idx_nxt;
  logic              w_busy, w_ready;
  logic              r_fetch_valid, r_fetch_fault, r_instr_zero, r_load_err;
  logic              w_fetch_go, w_fetch_addr_ok, w_load_go, w_load_addr_ok;
  logic              w_we, w_re;
  logic [IDX_W-1:0]  w_waddr;
  logic [WORD_W-1:0] w_wdata, w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_busy        = 1'b0;
    w_ready       = 1'b0;
    if (r_state == CLEAR) begin
      w_busy        = 1'b1;
      w_clr_idx_nxt = r_clr_idx + 1'b1;
      if (r_clr_idx == IDX_W'(DEPTH - 1)) begin
        w_state_nxt = IDLE;
      end
    end else begin
      w_ready = 1'b1;
    end
  end

  assign w_fetch_go      = fetch_req && (r_state == IDLE);
  assign w_fetch_addr_ok = addr_ok(fetch_addr);
  assign w_load_go       = load_valid && w_ready;
  assign w_load_addr_ok  = addr_ok(load_addr);

  // The clear sequence owns the write port; loads are only accepted once idle.
  assign w_we    = w_busy || (w_load_go && w_load_addr_ok);
  assign w_waddr = w_busy ? r_clr_idx : load_addr[IDX_W+1:2];
`ifdef IMEM_PARITY_EN
  assign w_wdata = w_busy ? '0 : {^load_data, load_data};
`else
  assign w_wdata = w_busy ? '0 : load_data;
`endif
  assign w_re    = w_fetch_go && w_fetch_addr_ok;

  imem_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (fetch_addr[IDX_W+1:2]),
    .o_rdata (w_rdata)
  );

  // r_instr_zero masks the read register after reset and on faulted fetches; both it and
  // the read register only change on an accepted fetch, so the outputs hold in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_instr_zero  <= 1'b1;
      r_load_err    <= 1'b0;
    end else begin
      r_fetch_valid <= w_fetch_go;
      r_load_err    <= w_load_go && !w_load_addr_ok;
      if (w_fetch_go) begin
        r_fetch_fault <= !w_fetch_addr_ok;
        r_instr_zero  <= !w_fetch_addr_ok;
      end
    end
  end

  assign fetch_valid = r_fetch_valid;
  assign fetch_fault = r_fetch_fault;
  assign fetch_instr = r_instr_zero ? '0 : w_rdata[DATA_W-1:0];
  assign load_err    = r_load_err;
  assign load_ready  = w_ready;
  assign busy        = w_busy;
`ifdef IMEM_PARITY_EN
  assign parity_err  = !r_instr_zero && (^w_rdata);
`endif

endmodule

// File: tb/tb_imem_bank.sv
// Self-checking bench for imem_bank: per-cycle comparison against a behavioural model plus
// directed literal checks. Exercises the parity path when IMEM_PARITY_EN is defined.
module tb_imem_bank;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_fault;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_err;
  logic              busy;
`ifdef IMEM_PARITY_EN
  logic              parity_err;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_err    (load_err),
    .busy        (busy)
`ifdef IMEM_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the bank is busy for DEPTH edges after reset release and reads as
  // all-zero afterwards; accepted fetches answer one cycle later from the pre-edge contents.
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_edges;
  logic              m_valid, m_fault, m_lerr;
  logic [DATA_W-1:0] m_instr;

  function automatic logic m_ok(input logic [ADDR_W-1:0] a);
    return (a % 4 == 0) && (a < 4 * DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0;
      m_valid <= 1'b0;
      m_fault <= 1'b0;
      m_lerr  <= 1'b0;
      m_instr <= '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else begin
      if (m_edges < 1000) m_edges <= m_edges + 1;
      m_valid <= (m_edges >= DEPTH) && fetch_req;
      m_lerr  <= (m_edges >= DEPTH) && load_valid && !m_ok(load_addr);
      if ((m_edges >= DEPTH) && fetch_req) begin
        m_fault <= !m_ok(fetch_addr);
        m_instr <= m_ok(fetch_addr) ? m_mem[fetch_addr / 4] : '0;
      end
      if ((m_edges >= DEPTH) && load_valid && m_ok(load_addr))
        m_mem[load_addr / 4] <= load_data;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_edges < DEPTH));
    chk("load_ready", 32'(load_ready), 32'(m_edges >= DEPTH));
    chk("fetch_valid", 32'(fetch_valid), 32'(m_valid));
    chk("fetch_instr", fetch_instr, m_instr);
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    chk("load_err", 32'(load_err), 32'(m_lerr));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req  = 1'b0;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    chk(name, 32'(n), 32'd64);
    chk({name, "_ready"}, 32'(load_ready), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_instr", fetch_instr, 32'h0);
    rst_n = 1'b1;

    // Fetches held during the clear are dropped; the first one after it returns zero.
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    count_busy("clear_len");
    step();
    fetch_req = 1'b0;
    chk("post_clear_valid", 32'(fetch_valid), 32'd1);
    chk("post_clear_instr", fetch_instr, 32'h0);

    load(32'h10, 32'h0000_0013);
    fetch(32'h10);
    chk("ld_fetch_valid", 32'(fetch_valid), 32'd1);
    chk("ld_fetch_instr", fetch_instr, 32'h0000_0013);
    chk("ld_fetch_fault", 32'(fetch_fault), 32'd0);
    step();
    chk("hold_valid", 32'(fetch_valid), 32'd0);
    chk("hold_instr", fetch_instr, 32'h0000_0013);

    fetch(32'h102);
    chk("misalign_fault", 32'(fetch_fault), 32'd1);
    chk("misalign_instr", fetch_instr, 32'h0);
    fetch(32'h100);
    chk("range_fault", 32'(fetch_fault), 32'd1);
    chk("range_instr", fetch_instr, 32'h0);
    load(32'h100, 32'hFFFF_FFFF);
    chk("load_err_pulse", 32'(load_err), 32'd1);
    step();
    chk("load_err_clear", 32'(load_err), 32'd0);
    fetch(32'h0);
    chk("alias_unchanged", fetch_instr, 32'h0);

    // Same-cycle load and fetch of one word returns the old contents.
    load_valid = 1'b1;
    load_addr  = 32'h8;
    load_data  = 32'hDEAD_BEEF;
    fetch(32'h8);
    load_valid = 1'b0;
    chk("rbw_old", fetch_instr, 32'h0);
    fetch(32'h8);
    chk("rbw_new", fetch_instr, 32'hDEAD_BEEF);

    fetch_req = 1'b1;
    foreach (fetch_addr[i]) if (i < 0) fetch_addr = '0;
    fetch_addr = 32'h10; step();
    chk("b2b_0", fetch_instr, 32'h0000_0013);
    fetch_addr = 32'h8;  step();
    chk("b2b_1", fetch_instr, 32'hDEAD_BEEF);
    fetch_addr = 32'hC;  step();
    chk("b2b_2", fetch_instr, 32'h0);
    chk("b2b_valid", 32'(fetch_valid), 32'd1);

`ifdef IMEM_PARITY_EN
    fetch_req = 1'b0;
    fetch(32'h10);
    chk("par_clean", 32'(parity_err), 32'd0);
    u_dut.u_array.r_mem[4][DATA_W] = ~u_dut.u_array.r_mem[4][DATA_W];
    fetch(32'h10);
    chk("par_flip", 32'(parity_err), 32'd1);
    fetch_req = 1'b1;
`endif

    // Reset mid-fetch clears the response immediately.
    fetch_addr = 32'h10;
    step();
    fetch_req = 1'b0;
    chk("midfetch_valid_pre", 32'(fetch_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midfetch_valid", 32'(fetch_valid), 32'd0);
    chk("midfetch_instr", fetch_instr, 32'h0);
    chk("midfetch_busy", 32'(busy), 32'd1);
    chk("midfetch_ready", 32'(load_ready), 32'd0);
    step();
    rst_n = 1'b1;

    // Reset 20 cycles into the clear restarts it from index 0.
    for (int i = 0; i < 20; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midclear_busy", 32'(busy), 32'd1);
    chk("midclear_err", 32'(load_err), 32'd0);
    step();
    rst_n = 1'b1;
    count_busy("reclear_len");
    fetch(32'h10);
    chk("reclear_instr", fetch_instr, 32'h0);
    fetch(32'h8);
    chk("reclear_instr2", fetch_instr, 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
